mlp_infer_engine: RTL
=====================

Name: mlp_infer_engine

Overview:
- Parametrised successor to the fixed two-layer MNIST-style inference controller.
- Runs FC1 -> scale -> ReLU -> FC2 -> scale -> argmax on one image (8-bit activations), or on two images at once (packed 4-bit activations, split mode).
- Contains its own HID_DIM-lane signed MAC array and two accumulator banks. Reads external weight and input buffers; reports a class index per image with a valid pulse.

Parameters:
- IN_DIM, 100, FC1 input length; also the number of FC1 weight rows.
- HID_DIM, 10, hidden neurons; equals the MAC lane count.
- OUT_DIM, 10, classes; must be <= HID_DIM; lanes >= OUT_DIM are ignored in FC2.
- ACC_W, 24, signed accumulator width per lane.
- SHIFT1, 2, arithmetic right shift applied after FC1.
- SHIFT2, 4, arithmetic right shift applied after FC2.
- ADDR_W, 8, buffer address width; IN_DIM+HID_DIM must be <= 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins an inference; sampled only when busy=0.
- split  in  1  mode, sampled with start: 0 = single 8-bit image, 1 = two 4-bit images.
- weight_addr  out  ADDR_W  weight buffer read address.
- weight_data  in  HID_DIM*8  one row, lane k at [8k+7:8k], signed.
- input_addr  out  ADDR_W  input buffer read address.
- input_data  in  16  pixel word.
- busy  out  1  high from the cycle after an accepted start until the cycle of the final valid.
- valid  out  1  one-cycle pulse per finished image.
- result_tag  out  1  image of the current result: 0 = A, 1 = B.
- inference_result  out  4  argmax class index.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset (also asynchronous mid-operation): FSM to IDLE. busy, valid, result_tag, inference_result, weight_addr, input_addr, accumulators and hidden registers all 0. No partial result is ever emitted after reset.
- Buffer reads: synchronous, 1-cycle latency. An address driven in cycle t returns data in cycle t+1. The FSM issues addresses one cycle ahead.
- Start: accepted only in IDLE. A start while busy=1 is ignored; mode and addresses are unchanged.
- FSM states: IDLE, FC1, SCL1, RELU, FC2, SCL2, ARGMAX, SWAP, FC2B, SCL2B, ARGMAXB.
- FC1, IN_DIM+1 cycles:
  - weight_addr and input_addr step 0..IN_DIM-1.
  - Each data beat does acc_k += w_k * x.
  - single: x = input_data[7:0], signed.
  - split: bank A uses sign-extended input_data[3:0]; bank B uses sign-extended input_data[11:8].
- SCL1: h_k = sat8(acc_k >>> SHIFT1) for each bank; accumulators are cleared.
- RELU: each negative h_k becomes 0.
- FC2, HID_DIM+1 cycles:
  - weight_addr steps IN_DIM..IN_DIM+HID_DIM-1.
  - Beat j does acc_k += w_k * hA_j.
- SCL2: logit_k = sat8(acc_k >>> SHIFT2).
- ARGMAX:
  - Over logit_0..OUT_DIM-1, signed compare; the lowest index wins ties.
  - Registers inference_result, pulses valid, result_tag=0.
- Image B path: if split, SWAP loads hB into the working hidden registers and clears the accumulators. FC2B, SCL2B and ARGMAXB then mirror FC2, SCL2 and ARGMAX with result_tag=1. Otherwise go to IDLE.
- After ARGMAXB, go to IDLE. The total valid count per start is 1 (single) or 2 (split).
- busy falls in the same cycle as the last valid pulse.
- inference_result and result_tag hold their values until the next ARGMAX.
- Arithmetic: products are 16-bit signed, sign-extended to ACC_W. Overflow wraps at ACC_W (the designer sizes ACC_W).
- sat8: clamps to [-128,127] when the optional feature is enabled (see Optional Feature).
- Address wrap: none inside a run; weight_addr and input_addr return to 0 on the next accepted start.

Optional Feature:
- Macro: MLP_INFER_SATURATE_EN.
- Defined: sat8 clamps the shifted value to [-128,127].
- Undefined: sat8 takes the low 8 bits of the shifted value (legacy truncation). This saves comparators.

Decomposition:
- Package mlp_infer_pkg holds:
  - the state enum/localparams;
  - MODE_SINGLE and MODE_SPLIT;
  - the lane byte-slice helper;
  - the sat8 function.
- Sub-module mlp_argmax: parametrised OUT_DIM comparator tree, combinational, lowest index on ties. It is instantiated once and shared by ARGMAX and ARGMAXB.

Test Plan:
- Single-mode run:
  - Stimulus: all weights 1, all pixels 1, default parameters.
  - Response: h_k = 25. logit_k = sat8(250>>>4) = 15. All logits tie, so the result is 0.
  - Expect exactly one valid pulse, at cycle IN_DIM+HID_DIM+7 after start, with result_tag=0.
- Split-mode run:
  - Stimulus: the FC2 row for class 3 is made largest; pixel nibble A = 1, nibble B = -1.
  - Response: image A gives 3. Image B hidden values are clamped to 0 by ReLU, so all B logits are 0 and the result is 0.
  - Expect two valid pulses, with tags 0 then 1.
- Saturation:
  - Stimulus: all weights 127, all pixels 127.
  - Response: with MLP_INFER_SATURATE_EN, h = 127. Without it, h = the low byte of (1612900>>>2).
- Start while busy:
  - Stimulus: pulse start with split=1 mid-FC1 of a single-mode run.
  - Response: it is ignored; one valid pulse only; the result is unchanged.
- Reset mid-FC2:
  - Stimulus: assert rst_n=0 asynchronously.
  - Response: all outputs are 0 immediately. A new start then gives a correct result with no stale valid pulse.
- Tie and negative logits:
  - Stimulus: logits [-5,-5,-2,-2,...].
  - Response: result is 2 (lowest index among the maxima).

Source files
------------

// File: rtl/mlp_infer_engine_pkg.sv
// mlp_infer_pkg: FSM states, image modes and lane/saturation helpers; MLP_INFER_SATURATE_EN makes sat8 clamp instead of truncate
package mlp_infer_pkg;
  typedef enum logic [3:0] {IDLE, FC1, SCL1, RELU, FC2, SCL2, ARGMAX, SWAP, FC2B, SCL2B, ARGMAXB} state_e;
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_SPLIT = 1'b1;
  localparam int MAX_LANES = 32;
  function automatic logic signed [7:0] lane_byte(input logic [MAX_LANES*8-1:0] row, input int k);
    return row[8*k +: 8];
  endfunction
  function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
`ifdef MLP_INFER_SATURATE_EN
    return v > 32'sd127 ? 8'h7f : v < -32'sd128 ? 8'h80 : v[7:0];
`else
    return 8'(v);
`endif
  endfunction
endpackage

// File: rtl/mlp_infer_engine_if.sv
// mlp_infer_engine_if: host handshake and weight/input buffer bus of the inference engine
interface mlp_infer_engine_if #(parameter int HID_DIM = 10, parameter int ADDR_W = 8);
  logic start, split, busy, valid, result_tag;
  logic [3:0] inference_result;
  logic [ADDR_W-1:0] weight_addr, input_addr;
  logic [HID_DIM*8-1:0] weight_data;
  logic [15:0] input_data;
  modport master (output start, split, weight_data, input_data,
                  input busy, valid, result_tag, inference_result, weight_addr, input_addr);
  modport slave (input start, split, weight_data, input_data,
                 output busy, valid, result_tag, inference_result, weight_addr, input_addr);
endinterface

// File: rtl/mlp_infer_engine_argmax.sv
// mlp_argmax: signed argmax over OUT_DIM packed bytes, lowest index wins ties
module mlp_argmax #(parameter int OUT_DIM = 10) (
  input  logic [OUT_DIM*8-1:0] logits_i,
  output logic [3:0]           idx_o
);
  logic signed [7:0] best;
  // Strict greater-than keeps the earliest maximum
  always_comb begin
    best = logits_i[7:0];
    idx_o = '0;
    for (int i = 1; i < OUT_DIM; i++)
      if ($signed(logits_i[8*i +: 8]) > best) begin
        best = logits_i[8*i +: 8];
        idx_o = 4'(i);
      end
  end
endmodule

// File: rtl/mlp_infer_engine.sv
// mlp_infer_engine: FC1 -> scale -> ReLU -> FC2 -> scale -> argmax on one 8-bit or two 4-bit images; MLP_INFER_SATURATE_EN selects clamping sat8
module mlp_infer_engine
  import mlp_infer_pkg::*;
#(
  parameter int IN_DIM = 100,
  parameter int HID_DIM = 10,
  parameter int OUT_DIM = 10,
  parameter int ACC_W = 24,
  parameter int SHIFT1 = 2,
  parameter int SHIFT2 = 4,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst_n,
  mlp_infer_engine_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  localparam int HW = $clog2(HID_DIM);
  localparam logic [CW-1:0] C_IN = CW'(IN_DIM);
  localparam logic [CW-1:0] C_HID = CW'(HID_DIM);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic split_q, valid_q, tag_q;
  logic [3:0] res_q, am_idx;
  logic [ADDR_W-1:0] waddr_q, iaddr_q;
  logic signed [ACC_W-1:0] acc_a_q [HID_DIM];
  logic signed [ACC_W-1:0] acc_b_q [HID_DIM];
  logic signed [7:0] h_a_q [HID_DIM];
  logic signed [7:0] h_b_q [HID_DIM];
  logic signed [7:0] w [HID_DIM];
  logic signed [15:0] pa [HID_DIM];
  logic signed [15:0] pb [HID_DIM];
  logic signed [7:0] xa, xb, xs;
  logic [OUT_DIM*8-1:0] logits;
  logic accept, beat, clr, unused_bits;
  assign accept = state_q == IDLE && bus.start;
  assign beat = (state_q == FC1 || state_q == FC2 || state_q == FC2B) && cnt_q != '0;
  assign clr = accept || state_q == SCL1 || state_q == SWAP;
  assign unused_bits = ^bus.input_data[15:12];
  assign bus.busy = state_q != IDLE;
  assign bus.valid = valid_q;
  assign bus.result_tag = tag_q;
  assign bus.inference_result = res_q;
  assign bus.weight_addr = waddr_q;
  assign bus.input_addr = iaddr_q;
  mlp_argmax #(.OUT_DIM(OUT_DIM)) u_argmax (.logits_i(logits), .idx_o(am_idx));
  // State register and per-state cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // Next state; the counter restarts on every state change
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = bus.start ? FC1 : IDLE;
      FC1:     state_d = cnt_q == C_IN ? SCL1 : FC1;
      SCL1:    state_d = RELU;
      RELU:    state_d = FC2;
      FC2:     state_d = cnt_q == C_HID ? SCL2 : FC2;
      SCL2:    state_d = ARGMAX;
      ARGMAX:  state_d = split_q == MODE_SPLIT ? SWAP : IDLE;
      SWAP:    state_d = FC2B;
      FC2B:    state_d = cnt_q == C_HID ? SCL2B : FC2B;
      SCL2B:   state_d = ARGMAXB;
      ARGMAXB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + C_ONE;
  end
  // Operand select and per-lane products; FC2 beat j (cnt j+1) consumes hidden value j
  always_comb begin
    xa = split_q == MODE_SPLIT ? {{4{bus.input_data[3]}}, bus.input_data[3:0]} : bus.input_data[7:0];
    xb = {{4{bus.input_data[11]}}, bus.input_data[11:8]};
    xs = state_q == FC1 ? xa : h_a_q[HW'(cnt_q - C_ONE)];
    logits = '0;
    for (int k = 0; k < HID_DIM; k++) begin
      w[k] = lane_byte((MAX_LANES*8)'(bus.weight_data), k);
      pa[k] = 16'(w[k]) * 16'(xs);
      pb[k] = 16'(w[k]) * 16'(xb);
    end
    for (int k = 0; k < OUT_DIM; k++) logits[8*k +: 8] = h_a_q[k];
  end
  // Addresses run one cycle ahead of data; logits reuse the working hidden registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_q <= MODE_SINGLE;
      valid_q <= 1'b0;
      tag_q <= 1'b0;
      res_q <= '0;
      waddr_q <= '0;
      iaddr_q <= '0;
      for (int k = 0; k < HID_DIM; k++) begin
        acc_a_q[k] <= '0;
        acc_b_q[k] <= '0;
        h_a_q[k] <= '0;
        h_b_q[k] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        split_q <= bus.split ? MODE_SPLIT : MODE_SINGLE;
        waddr_q <= '0;
        iaddr_q <= '0;
      end
      if (state_q == FC1 && cnt_q < C_IN) waddr_q <= waddr_q + ADDR_W'(1);
      if (state_q == FC1 && cnt_q < C_IN - C_ONE) iaddr_q <= iaddr_q + ADDR_W'(1);
      if ((state_q == FC2 || state_q == FC2B) && cnt_q < C_HID - C_ONE) waddr_q <= waddr_q + ADDR_W'(1);
      if (state_q == SWAP) waddr_q <= ADDR_W'(IN_DIM);
      if (state_q == ARGMAX || state_q == ARGMAXB) begin
        valid_q <= 1'b1;
        tag_q <= state_q == ARGMAXB;
        res_q <= am_idx;
      end
      for (int k = 0; k < HID_DIM; k++) begin
        if (clr) begin
          acc_a_q[k] <= '0;
          acc_b_q[k] <= '0;
        end else if (beat) begin
          acc_a_q[k] <= acc_a_q[k] + ACC_W'(pa[k]);
          if (state_q == FC1 && split_q == MODE_SPLIT) acc_b_q[k] <= acc_b_q[k] + ACC_W'(pb[k]);
        end
        if (state_q == SCL1) begin
          h_a_q[k] <= sat8(32'(acc_a_q[k] >>> SHIFT1));
          h_b_q[k] <= sat8(32'(acc_b_q[k] >>> SHIFT1));
        end
        if (state_q == RELU) begin
          h_a_q[k] <= h_a_q[k][7] ? '0 : h_a_q[k];
          h_b_q[k] <= h_b_q[k][7] ? '0 : h_b_q[k];
        end
        if (state_q == SCL2 || state_q == SCL2B) h_a_q[k] <= sat8(32'(acc_a_q[k] >>> SHIFT2));
        if (state_q == SWAP) h_a_q[k] <= h_b_q[k];
      end
    end
  end
endmodule
